// File: rtl/dbus_interconnect_if.sv
// CPU data-port and slave-side bus bundle for the data-bus interconnect.
// Pure wiring, no latency of its own.
// Backpressure comes from the slave ready lines and is reflected to the CPU as busy.
interface dbus_interconnect_if #(
  parameter int N_SLV = 4
);

  // CPU request side
  logic [31:0]         i_addr;
  logic [31:0]         i_wdata;
  logic [3:0]          i_wr;
  logic                i_rd;

  // CPU response side
  logic [31:0]         o_rdata;
  logic                o_ack;
  logic                o_err;
  logic                o_busy;

  // Shared slave request bus; each slave sees its own chip select
  logic [N_SLV-1:0]    o_s_cs;
  logic [31:0]         o_s_addr;
  logic [31:0]         o_s_wdata;
  logic [3:0]          o_s_wr;
  logic                o_s_rd;

  // Per-slave response lanes, concatenated with slave 0 in the low bits
  logic [32*N_SLV-1:0] i_s_rdata;
  logic [N_SLV-1:0]    i_s_ready;

  // Sticky fault capture
  logic                i_fault_clr;
  logic                o_fault_valid;
  logic [31:0]         o_fault_addr;
  logic                o_fault_type;

  // Interconnect view
  modport slave (
    input  i_addr, i_wdata, i_wr, i_rd,
    output o_rdata, o_ack, o_err, o_busy,
    output o_s_cs, o_s_addr, o_s_wdata, o_s_wr, o_s_rd,
    input  i_s_rdata, i_s_ready,
    input  i_fault_clr,
    output o_fault_valid, o_fault_addr, o_fault_type
  );

  // CPU plus slave-model view
  modport master (
    output i_addr, i_wdata, i_wr, i_rd,
    input  o_rdata, o_ack, o_err, o_busy,
    input  o_s_cs, o_s_addr, o_s_wdata, o_s_wr, o_s_rd,
    output i_s_rdata, i_s_ready,
    output i_fault_clr,
    input  o_fault_valid, o_fault_addr, o_fault_type
  );

endinterface

// File: rtl/dbus_interconnect.sv
// Data-bus interconnect: mask/base decode of the CPU data port onto N_SLV slaves, with watchdog and fault capture.
// Latency: request -> cs 1 cycle, ack 2 cycles plus slave wait cycles; decode error 2 cycles; timeout TIMEOUT+1 cycles.
// Backpressure: slaves insert wait states by holding ready low; CPU stalls on o_busy and inputs are ignored while busy.
module dbus_interconnect #(
  parameter int                  N_SLV    = 4,
  parameter logic [32*N_SLV-1:0] SLV_BASE = {32'h00010000, 32'h00008010, 32'h00008000, 32'h00000000},
  parameter logic [32*N_SLV-1:0] SLV_MASK = {32'hFFFFF800, 32'hFFFFFFFC, 32'hFFFFFFF0, 32'hFFFF8000},
  parameter int                  TIMEOUT  = 16,
  parameter logic [31:0]         ERR_DATA = 32'hDEADBEEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  dbus_interconnect_if.slave  bus
);

  // Counter holds up to TIMEOUT so the increment on the abort cycle cannot wrap
  localparam int             CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERROR  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [N_SLV-1:0]  cs_q, cs_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              fvld_q, fvld_d;
  logic [31:0]       faddr_q, faddr_d;
  logic              ftype_q, ftype_d;

  logic [N_SLV-1:0]  hit_vec;
  logic [N_SLV-1:0]  dec_onehot;
  logic              req;
  logic [31:0]       sel_rdata;
  logic              sel_ready;

  // Compare the live CPU address against every slave window
  always_comb begin
    hit_vec = '0;
    for (int k = 0; k < N_SLV; k++) begin
      hit_vec[k] = (bus.i_addr & SLV_MASK[32*k +: 32]) == SLV_BASE[32*k +: 32];
    end
  end

  // Isolating the lowest set bit gives lowest-index priority on overlapping windows
  assign dec_onehot = hit_vec & (~hit_vec + N_SLV'(1));
  assign req        = bus.i_rd | (|bus.i_wr);

  // Only the selected slave's lane reaches the response path; others are masked by cs
  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < N_SLV; k++) begin
      if (cs_q[k]) begin
        sel_rdata = sel_rdata | bus.i_s_rdata[32*k +: 32];
      end
    end
  end

  assign sel_ready = |(bus.i_s_ready & cs_q);

  // Next-state and next-output logic; everything holds unless a state acts on it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    cs_d    = cs_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    fvld_d  = bus.i_fault_clr ? 1'b0 : fvld_q;
    faddr_d = faddr_q;
    ftype_d = ftype_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = bus.i_addr;
          wdata_d = bus.i_wdata;
          wr_d    = bus.i_wr;
          rd_d    = bus.i_rd;
          busy_d  = 1'b1;
          cnt_d   = '0;
          if (|dec_onehot) begin
            cs_d    = dec_onehot;
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end

      ST_ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        // A ready on the last counted cycle still completes normally
        if (sel_ready) begin
          rdata_d = sel_rdata;
          ack_d   = 1'b1;
          cs_d    = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = ERR_DATA;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          cs_d    = '0;
          busy_d  = 1'b0;
          fvld_d  = 1'b1;
          faddr_d = addr_q;
          ftype_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_ERROR: begin
        rdata_d = ERR_DATA;
        ack_d   = 1'b1;
        err_d   = 1'b1;
        busy_d  = 1'b0;
        fvld_d  = 1'b1;
        faddr_d = addr_q;
        ftype_d = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        cs_d    = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears cs and busy at once, killing any transfer in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      cs_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= '0;
      rd_q    <= 1'b0;
      fvld_q  <= 1'b0;
      faddr_q <= '0;
      ftype_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      cs_q    <= cs_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fvld_q  <= fvld_d;
      faddr_q <= faddr_d;
      ftype_q <= ftype_d;
    end
  end

  assign bus.o_rdata       = rdata_q;
  assign bus.o_ack         = ack_q;
  assign bus.o_err         = err_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_s_cs        = cs_q;
  assign bus.o_s_addr      = addr_q;
  assign bus.o_s_wdata     = wdata_q;
  // Strobes stay latched but are only visible to slaves while a chip select is active
  assign bus.o_s_wr        = (|cs_q) ? wr_q : 4'b0000;
  assign bus.o_s_rd        = (|cs_q) ? rd_q : 1'b0;
  assign bus.o_fault_valid = fvld_q;
  assign bus.o_fault_addr  = faddr_q;
  assign bus.o_fault_type  = ftype_q;

endmodule

// File: doc/dbus_interconnect.md
Name: dbus_interconnect

Overview:
- Parametrised data-bus interconnect between the CPU data port and N memory-mapped slaves (RAM, UART, GPIO, boot region, future peripherals).
- Replaces the flat combinational address-compare and read-data mux with the following:
  - a per-slave mask/base address map;
  - registered request and response;
  - a slave ready handshake for wait states;
  - a timeout watchdog;
  - a sticky fault-capture register for decode and timeout errors.

Parameters:
- N_SLV, 4, number of slave ports (1..8).
- SLV_BASE, {32'h00010000, 32'h00008010, 32'h00008000, 32'h00000000}, concatenated per-slave base addresses; slave k occupies bits [32k+31:32k].
- SLV_MASK, {32'hFFFFF800, 32'hFFFFFFFC, 32'hFFFFFFF0, 32'hFFFF8000}, concatenated per-slave address masks.
- TIMEOUT, 16, cycles in ACCESS without i_s_ready before abort (>=2).
- ERR_DATA, 32'hDEADBEEF, read data returned on any error.

Ports:
- i_clk, in, 1, system clock; all logic on the rising edge.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_addr, in, 32, CPU byte address.
- i_wdata, in, 32, CPU write data.
- i_wr, in, 4, CPU byte write strobes.
- i_rd, in, 1, CPU read request.
- o_rdata, out, 32, response read data.
- o_ack, out, 1, one-cycle completion pulse.
- o_err, out, 1, qualifies o_ack as an error completion.
- o_busy, out, 1, transaction in flight; CPU must stall while high.
- o_s_cs, out, N_SLV, one-hot slave select.
- o_s_addr, out, 32, registered address, shared by all slaves.
- o_s_wdata, out, 32, registered write data, shared.
- o_s_wr, out, 4, registered write strobes, shared; gated by an active cs.
- o_s_rd, out, 1, registered read strobe, shared; gated by an active cs.
- i_s_rdata, in, 32*N_SLV, slave read data, concatenated.
- i_s_ready, in, N_SLV, slave completion, concatenated.
- i_fault_clr, in, 1, clears the fault register.
- o_fault_valid, out, 1, sticky: an error has occurred since the last clear.
- o_fault_addr, out, 32, address of the most recent error.
- o_fault_type, out, 1, 0 = decode error, 1 = timeout.

Behaviour:
- Reset (async, i_rst_n=0) forces all outputs to 0:
  - o_rdata, o_ack, o_err, o_busy, o_s_cs, o_s_addr, o_s_wdata, o_s_wr, o_s_rd;
  - o_fault_valid, o_fault_addr, o_fault_type;
  - state=IDLE, timeout counter=0.
- Reset during ACCESS drops cs and strobes immediately. No ack is produced for the aborted transfer.
- Decode: slave k matches when (i_addr & MASK_k) == BASE_k. Lowest matching index wins. No match means a decode error.
- FSM states:
  - IDLE: a request is present when i_rd or |i_wr. On a request edge:
    - register addr, wdata, wr, rd;
    - set o_busy=1;
    - go to ACCESS with o_s_cs one-hot for a hit, or to ERROR for a miss.
    - Inputs are ignored in all states other than IDLE.
  - ACCESS: cs and strobes are held stable; the counter increments each cycle.
    - When i_s_ready[sel]=1: latch i_s_rdata[sel] into o_rdata, pulse o_ack, clear cs/strobes/busy, go to IDLE.
    - If the counter reaches TIMEOUT-1 with no ready: abort, o_rdata=ERR_DATA, o_ack=1, o_err=1, record the fault with type=1, go to IDLE.
  - ERROR (one cycle): o_rdata=ERR_DATA, o_ack=1, o_err=1, record the fault with type=0, go to IDLE.
- Latency:
  - Zero-wait slave: request at cycle 0, cs at cycle 1, ack at cycle 2.
  - Each wait cycle adds 1.
  - Decode error: ack+err at cycle 2.
  - Timeout: ack+err TIMEOUT+1 cycles after the request.
- Completion on the ack cycle:
  - o_busy falls on the same edge as o_ack.
  - A new request can be accepted in the cycle after the ack (IDLE).
- o_rdata keeps its last value until the next completion. It is also updated on writes, using the slave's data.
- Read and write in the same request: both strobes are forwarded; read data is returned.
- Only the selected slave's ready is honoured. Ready from other slaves is ignored.
- Fault register:
  - On error: o_fault_valid=1 and the address/type are overwritten.
  - i_fault_clr clears o_fault_valid only.
  - Error and clear in the same cycle: the error wins (valid stays 1, new address).
- Counter: $clog2(TIMEOUT)+1 bits, reset to 0 on entry to ACCESS. No wrap is possible.

Test Plan:
- Read 0x00000010 with slave 0 ready at cycle 1 returning 0x12345678 -> o_s_cs=4'b0001 on cycle 1; o_ack, o_rdata=0x12345678, o_err=0 at cycle 2.
- Write 0x00008004, i_wr=4'b1111, data 0xA5, slave 1 ready after 3 wait cycles -> cs=4'b0010 and o_s_wr=4'b1111 held 4 cycles; ack at cycle 5; o_busy high cycles 1-4.
- Read 0x00020000 (unmapped) -> ack+err at cycle 2, o_rdata=0xDEADBEEF, fault_valid=1, fault_addr=0x00020000, type=0.
- Read 0x00008010 with slave 2 never ready, TIMEOUT=16 -> ack+err at cycle 17, cs dropped, fault type=1; then i_fault_clr -> fault_valid=0, fault_addr unchanged.
- Assert i_rst_n=0 mid-ACCESS -> o_s_cs=0 and o_busy=0 immediately, no ack; after release, a fresh read completes normally.
- Slave 3 ready asserted while slave 0 selected, plus a new CPU request during busy -> both ignored; completion occurs only on slave 0 ready.
